instruction_sequencer: RTL and testbench
========================================

// Module: instruction_sequencer
// PURPOSE
// - Program-counter sequencer for the 28-bit instruction ROM: drives the ROM address and decides the next fetch.
// - Decisions come from decoded control strobes: sequential, JMP/BLE-taken, CALL/RET (hardware return-address stack) and NOP delay.
// - Sits between the ROM and the execute stage. The decoder supplies control strobes; no opcode encoding is known here.
// PARAMETERS
// - ADDR_W       16  width of the PC / ROM address
// - STACK_DEPTH   8  return-address stack entries (power of two, >=2)
// - DELAY_W      24  width of the NOP delay count
// PORTS
// - Clock          in   1                         system clock, rising edge
// - Reset          in   1                         asynchronous, active-low; clears all state
// - iEnable        in   1                         advance permitted; 0 freezes PC, stack, delay counter
// - iJump          in   1                         JMP at oAddress
// - iBranchTaken   in   1                         BLE at oAddress, condition true
// - iCall          in   1                         CALL at oAddress
// - iRet           in   1                         RET at oAddress
// - iDelay         in   1                         NOP-with-delay at oAddress
// - iTarget        in   8                         jump/call target, zero-extended to ADDR_W
// - iDelayCount    in   DELAY_W                   NOP delay length in cycles
// - oAddress       out  ADDR_W                    ROM address (registered)
// - oValid         out  1                         instruction at oAddress executes this cycle
// - oDepth         out  $clog2(STACK_DEPTH+1)     stack occupancy
// - oOverflow      out  1                         sticky: CALL with stack full
// - oUnderflow     out  1                         sticky: RET with stack empty
// - oHalted        out  1                         sequencer in HALT state
// BEHAVIOUR
// - Reset values: oAddress=0, oValid=0, oDepth=0, oOverflow=0, oUnderflow=0, oHalted=0; state=START.
// - States: START -> RUN (next edge; oValid=0 in START). RUN -> DELAY / HALT. DELAY -> RUN.
// - Instruction accepted = state RUN && oValid && iEnable; control strobes are ignored otherwise.
// - Next-PC on accept, priority order iRet > iCall > (iJump|iBranchTaken) > iDelay > sequential:
// -   iRet: pop; PC <= top of stack. iCall: push PC+1; PC <= {0,iTarget}.
// -   jump/branch: PC <= {0,iTarget}. sequential: PC <= PC+1, modulo 2^ADDR_W (wraps at all-ones).
// -   iDelay with N=iDelayCount: N=0 -> plain NOP (PC+1 next cycle).
// -     N>=1 -> DELAY; oValid=0 for exactly N enabled cycles; then RUN with oAddress=PC+1, oValid=1.
// - Latency: the new oAddress is valid the cycle after accept; one instruction per cycle in RUN.
// - iEnable=0 in DELAY: the counter holds and the cycle does not count toward N.
// - Stack: push and pop never occur in the same cycle (priority). oDepth updates with the edge that pushes or pops.
// - Reset asserted mid-DELAY or mid-call chain: immediate clear, fetch restarts at address 0; stack contents are discarded.
// CONFIGURATION
// - Macro SEQ_FAULT_HALT_EN.
// - Defined: CALL on full or RET on empty sets the sticky flag and moves to HALT.
// -   HALT: oValid=0, oHalted=1, PC and stack frozen; exit only via Reset.
// - Undefined: the flag is set, oHalted stays 0, and execution continues.
// -   Overflow: push discarded, branch to target still taken, oDepth stays STACK_DEPTH.
// -   Underflow: PC <= 0, oDepth stays 0.
// TESTING
// - Reset release, no strobes, iEnable=1: oValid=0 for 1 cycle, then oAddress 0,1,2,3 on consecutive cycles.
// - At addr 4: iCall, iTarget=14. Then oAddress=14, oDepth=1; iRet at 19 -> oAddress=5, oDepth=0.
// - iDelay at addr 0 with iDelayCount=3: oValid=0 for 3 cycles, then oAddress=1, oValid=1.
//   Repeat with count 0: oAddress=1 on the next cycle.
// - 9 nested CALLs with STACK_DEPTH=8:
//   with SEQ_FAULT_HALT_EN, oOverflow=1, oHalted=1, oValid=0 held;
//   without it, oOverflow=1, oAddress=target, oDepth=8.
// - iRet with empty stack: oUnderflow=1. Without the macro, oAddress=0 next cycle.
//   iRet+iJump together: the RET path is taken.
// - Reset pulsed during DELAY (count 4000) at depth 2: all outputs at reset values, restart from 0, oDepth=0.

Source files
------------

// File: rtl/instruction_sequencer.sv
// Program-counter sequencer for the instruction ROM: sequential fetch, jump/branch,
// CALL/RET via a hardware return stack, and NOP delay. Optional macro: SEQ_FAULT_HALT_EN.
module instruction_sequencer #(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned STACK_DEPTH = 8,
   parameter int unsigned DELAY_W     = 24
) (
   input  logic                               Clock,
   input  logic                               Reset,
   input  logic                               iEnable,
   input  logic                               iJump,
   input  logic                               iBranchTaken,
   input  logic                               iCall,
   input  logic                               iRet,
   input  logic                               iDelay,
   input  logic [7:0]                         iTarget,
   input  logic [DELAY_W-1:0]                 iDelayCount,
   output logic [ADDR_W-1:0]                  oAddress,
   output logic                               oValid,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   oDepth,
   output logic                               oOverflow,
   output logic                               oUnderflow,
   output logic                               oHalted
);

   localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
   localparam int unsigned PTR_W   = $clog2(STACK_DEPTH);

   typedef enum logic [1:0] {S_START, S_RUN, S_DELAY, S_HALT} state_t;

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic [DEPTH_W-1:0]   depth_q, depth_d;
   logic [DELAY_W-1:0]   cnt_q, cnt_d;
   logic                 ovf_q, ovf_d;
   logic                 unf_q, unf_d;
   logic [ADDR_W-1:0]    stack_q [STACK_DEPTH];
   logic                 push_en;

   logic [ADDR_W-1:0]    pc_inc;
   logic [ADDR_W-1:0]    target_ext;
   logic [ADDR_W-1:0]    stack_top;

   assign pc_inc     = pc_q + 1'b1;
   assign target_ext = ADDR_W'(iTarget);
   assign stack_top  = stack_q[PTR_W'(depth_q - DEPTH_W'(1))];

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      depth_d = depth_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push_en = 1'b0;
      case (state_q)
         S_START: state_d = S_RUN;
         S_RUN: begin
            if (iEnable) begin
               if (iRet) begin
                  if (depth_q == '0) begin
                     unf_d = 1'b1;
`ifdef SEQ_FAULT_HALT_EN
                     state_d = S_HALT;
`else
                     pc_d = '0;
`endif
                  end else begin
                     pc_d    = stack_top;
                     depth_d = depth_q - DEPTH_W'(1);
                  end
               end else if (iCall) begin
                  if (depth_q == DEPTH_W'(STACK_DEPTH)) begin
                     ovf_d = 1'b1;
`ifdef SEQ_FAULT_HALT_EN
                     state_d = S_HALT;
`else
                     pc_d = target_ext;
`endif
                  end else begin
                     push_en = 1'b1;
                     depth_d = depth_q + DEPTH_W'(1);
                     pc_d    = target_ext;
                  end
               end else if (iJump || iBranchTaken) begin
                  pc_d = target_ext;
               end else if (iDelay && (iDelayCount != '0)) begin
                  // PC stays on the NOP; it advances when the count expires
                  state_d = S_DELAY;
                  cnt_d   = iDelayCount;
               end else begin
                  pc_d = pc_inc;
               end
            end
         end
         S_DELAY: begin
            if (iEnable) begin
               if (cnt_q == DELAY_W'(1)) begin
                  state_d = S_RUN;
                  pc_d    = pc_inc;
               end else begin
                  cnt_d = cnt_q - DELAY_W'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_START;
         pc_q    <= '0;
         depth_q <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         depth_q <= depth_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         stack_q <= '{default: '0};
      end else if (push_en) begin
         stack_q[depth_q[PTR_W-1:0]] <= pc_inc;
      end
   end

   assign oAddress   = pc_q;
   assign oValid     = (state_q == S_RUN);
   assign oDepth     = depth_q;
   assign oOverflow  = ovf_q;
   assign oUnderflow = unf_q;
   assign oHalted    = (state_q == S_HALT);

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer; expectations adapt to SEQ_FAULT_HALT_EN.
module tb_instruction_sequencer;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        iEnable, iJump, iBranchTaken, iCall, iRet, iDelay;
   logic [7:0]  iTarget;
   logic [23:0] iDelayCount;
   logic [15:0] oAddress;
   logic        oValid;
   logic [3:0]  oDepth;
   logic        oOverflow, oUnderflow, oHalted;

   int unsigned total = 0;
   int unsigned bad   = 0;

   instruction_sequencer #(.ADDR_W(16), .STACK_DEPTH(8), .DELAY_W(24)) dut (
      .Clock(Clock), .Reset(Reset), .iEnable(iEnable), .iJump(iJump),
      .iBranchTaken(iBranchTaken), .iCall(iCall), .iRet(iRet), .iDelay(iDelay),
      .iTarget(iTarget), .iDelayCount(iDelayCount), .oAddress(oAddress),
      .oValid(oValid), .oDepth(oDepth), .oOverflow(oOverflow),
      .oUnderflow(oUnderflow), .oHalted(oHalted)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic idle();
      iJump = 0; iBranchTaken = 0; iCall = 0; iRet = 0; iDelay = 0;
      iTarget = 0; iDelayCount = 0; iEnable = 1;
   endtask

   // Leaves the sequencer in RUN at address 0
   task automatic restart();
      idle();
      Reset = 0;
      tick();
      Reset = 1;
      tick();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".addr"}, 32'(oAddress), 0);
      check({tag, ".valid"}, 32'(oValid), 0);
      check({tag, ".depth"}, 32'(oDepth), 0);
      check({tag, ".ovf"}, 32'(oOverflow), 0);
      check({tag, ".unf"}, 32'(oUnderflow), 0);
      check({tag, ".halt"}, 32'(oHalted), 0);
   endtask

   initial begin
      idle();
      Reset = 0;
      #2;
      check_reset_vals("rst");
      tick(); tick();
      Reset = 1;
      check("start.valid", 32'(oValid), 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("seq.valid", 32'(oValid), 1);
         check("seq.addr", 32'(oAddress), 32'(i));
      end

      // CALL at 4 -> 14, RET at 19 -> 5
      iCall = 1; iTarget = 8'd14;
      tick();
      idle();
      check("call.addr", 32'(oAddress), 14);
      check("call.depth", 32'(oDepth), 1);
      for (int i = 0; i < 5; i++) tick();
      check("pre_ret.addr", 32'(oAddress), 19);
      iRet = 1;
      tick();
      idle();
      check("ret.addr", 32'(oAddress), 5);
      check("ret.depth", 32'(oDepth), 0);

      // iEnable=0 freezes PC and ignores strobes
      restart();
      iEnable = 0; iJump = 1; iTarget = 8'd77;
      tick();
      check("freeze.addr", 32'(oAddress), 0);
      iEnable = 1;
      tick();
      idle();
      check("jump.addr", 32'(oAddress), 77);
      iBranchTaken = 1; iTarget = 8'd200;
      tick();
      idle();
      check("branch.addr", 32'(oAddress), 200);

      // NOP delay of 3 with one frozen cycle inside
      restart();
      iDelay = 1; iDelayCount = 24'd3;
      tick();
      idle();
      check("dly.v1", 32'(oValid), 0);
      iEnable = 0;
      tick();
      check("dly.hold", 32'(oValid), 0);
      iEnable = 1;
      tick();
      check("dly.v2", 32'(oValid), 0);
      tick();
      check("dly.v3", 32'(oValid), 0);
      tick();
      check("dly.end.valid", 32'(oValid), 1);
      check("dly.end.addr", 32'(oAddress), 1);

      restart();
      iDelay = 1; iDelayCount = 24'd0;
      tick();
      idle();
      check("dly0.valid", 32'(oValid), 1);
      check("dly0.addr", 32'(oAddress), 1);

      // Nine nested calls into an 8-deep stack
      restart();
      for (int i = 0; i < 8; i++) begin
         iCall = 1; iTarget = 8'(20 + i);
         tick();
         check("nest.addr", 32'(oAddress), 32'(20 + i));
         check("nest.depth", 32'(oDepth), 32'(i + 1));
      end
      iCall = 1; iTarget = 8'd40;
      tick();
      idle();
      check("ovf.flag", 32'(oOverflow), 1);
      check("ovf.depth", 32'(oDepth), 8);
`ifdef SEQ_FAULT_HALT_EN
      check("ovf.halt", 32'(oHalted), 1);
      check("ovf.valid", 32'(oValid), 0);
      check("ovf.addr", 32'(oAddress), 27);
      tick(); tick();
      check("ovf.halt_hold", 32'(oHalted), 1);
      check("ovf.valid_hold", 32'(oValid), 0);
`else
      check("ovf.halt", 32'(oHalted), 0);
      check("ovf.addr", 32'(oAddress), 40);
      iRet = 1;
      tick();
      idle();
      check("unwind.addr", 32'(oAddress), 27);
      check("unwind.depth", 32'(oDepth), 7);
      check("ovf.sticky", 32'(oOverflow), 1);
`endif

      // RET on empty stack together with JMP
      restart();
      iRet = 1; iJump = 1; iTarget = 8'd9;
      tick();
      idle();
      check("unf.flag", 32'(oUnderflow), 1);
      check("unf.depth", 32'(oDepth), 0);
`ifdef SEQ_FAULT_HALT_EN
      check("unf.halt", 32'(oHalted), 1);
      check("unf.valid", 32'(oValid), 0);
`else
      check("unf.halt", 32'(oHalted), 0);
      check("unf.addr", 32'(oAddress), 0);
      tick();
      check("unf.sticky", 32'(oUnderflow), 1);
      check("unf.next", 32'(oAddress), 1);
`endif

      // RET beats JMP with a populated stack
      restart();
      iCall = 1; iTarget = 8'd30;
      tick();
      idle();
      iRet = 1; iJump = 1; iTarget = 8'd50;
      tick();
      idle();
      check("retjmp.addr", 32'(oAddress), 1);
      check("retjmp.depth", 32'(oDepth), 0);

      // Reset during a long delay at depth 2
      restart();
      iCall = 1; iTarget = 8'd10;
      tick();
      iTarget = 8'd12;
      tick();
      idle();
      check("rdly.depth", 32'(oDepth), 2);
      iDelay = 1; iDelayCount = 24'd4000;
      tick();
      idle();
      tick(); tick();
      check("rdly.in_delay", 32'(oValid), 0);
      Reset = 0;
      #2;
      check_reset_vals("rdly");
      tick();
      Reset = 1;
      tick();
      check("rdly.restart.valid", 32'(oValid), 1);
      check("rdly.restart.addr", 32'(oAddress), 0);
      check("rdly.restart.depth", 32'(oDepth), 0);
      tick();
      check("rdly.restart.next", 32'(oAddress), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
